// File: rtl/approx_adder_err_sequencer_if.sv
// Operand/result bundle between an operand source and the approximate-adder error sequencer.
// The optional squared-error path is controlled by APPROX_SEQ_SQ_ERR_EN in the sequencer.
interface approx_adder_err_sequencer_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16,
   parameter int ACC_W = 48
) ();
   logic             start;
   logic [CNT_W-1:0] num_samples;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH:0]   add_sum;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] err_count;
   logic [ACC_W-1:0] sum_abs_err;
   logic [WIDTH:0]   max_abs_err;
   logic [ACC_W-1:0] sum_sq_err;

   // Handshake: a pair transfers on a rising clk edge where in_valid && in_ready; in_a/in_b must
   // be stable while in_valid is high, and an unaccepted pair is simply not consumed.
   modport master (
      output start, num_samples, in_valid, in_a, in_b, add_sum,
      input  in_ready, add_a, add_b, busy, done,
      input  err_count, sum_abs_err, max_abs_err, sum_sq_err
   );

   modport slave (
      input  start, num_samples, in_valid, in_a, in_b, add_sum,
      output in_ready, add_a, add_b, busy, done,
      output err_count, sum_abs_err, max_abs_err, sum_sq_err
   );
endinterface

// File: rtl/approx_adder_err_sequencer.sv
// Streams operand pairs into an external approximate adder and accumulates error statistics.
// Define APPROX_SEQ_SQ_ERR_EN to add the squared-error accumulator.
module approx_adder_err_sequencer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16,
   parameter int ACC_W = 48
) (
   input  logic                           clk,
   input  logic                           rst,
   approx_adder_err_sequencer_if.slave    bus,
   output logic [1:0]                     state_o
);

   localparam int RES_W = WIDTH + 1;
   localparam int SUM_W = ((ACC_W > RES_W) ? ACC_W : RES_W) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   remaining_q, remaining_d;
   logic [WIDTH-1:0]   add_a_q, add_a_d;
   logic [WIDTH-1:0]   add_b_q, add_b_d;
   logic               s1_vld_q, s1_vld_d;
   logic               s2_vld_q, s2_vld_d;
   logic               clear_stats;

   logic [RES_W-1:0]   exact;
   logic [RES_W-1:0]   abs_d, abs_q;

   logic [CNT_W-1:0]   err_cnt_q;
   logic [ACC_W-1:0]   sum_abs_q;
   logic [RES_W-1:0]   max_abs_q;
   logic [SUM_W-1:0]   sum_abs_ext;

   assign s2_vld_d = s1_vld_q;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      s1_vld_d    = 1'b0;
      clear_stats = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               clear_stats = 1'b1;
               remaining_d = bus.num_samples;
               state_d     = (bus.num_samples == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (bus.in_valid) begin
               add_a_d     = bus.in_a;
               add_b_d     = bus.in_b;
               s1_vld_d    = 1'b1;
               remaining_d = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Leave as the last pair retires into the accumulators, so done and final stats coincide.
            if (!s1_vld_d && !s2_vld_d) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         s1_vld_q    <= 1'b0;
         s2_vld_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         s1_vld_q    <= s1_vld_d;
         s2_vld_q    <= s2_vld_d;
      end
   end

   // Magnitude computed by ordered subtraction so no sign bit needs to be carried.
   always_comb begin
      exact = {1'b0, add_a_q} + {1'b0, add_b_q};
      if (exact >= bus.add_sum) begin
         abs_d = exact - bus.add_sum;
      end else begin
         abs_d = bus.add_sum - exact;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         abs_q <= '0;
      end else if (s1_vld_q) begin
         abs_q <= abs_d;
      end
   end

   assign sum_abs_ext = SUM_W'(sum_abs_q) + SUM_W'(abs_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
         sum_abs_q <= '0;
         max_abs_q <= '0;
      end else if (clear_stats) begin
         err_cnt_q <= '0;
         sum_abs_q <= '0;
         max_abs_q <= '0;
      end else if (s2_vld_q) begin
         if ((abs_q != '0) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
         end
         if (sum_abs_ext[SUM_W-1:ACC_W] != '0) begin
            sum_abs_q <= '1;
         end else begin
            sum_abs_q <= sum_abs_ext[ACC_W-1:0];
         end
         if (abs_q > max_abs_q) begin
            max_abs_q <= abs_q;
         end
      end
   end

`ifdef APPROX_SEQ_SQ_ERR_EN
   localparam int SQ_W  = 2 * RES_W;
   localparam int SQS_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

   logic [SQ_W-1:0]  sq_q;
   logic [ACC_W-1:0] sum_sq_q;
   logic [SQS_W-1:0] sum_sq_ext;

   assign sum_sq_ext = SQS_W'(sum_sq_q) + SQS_W'(sq_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sq_q <= '0;
      end else if (s1_vld_q) begin
         sq_q <= SQ_W'(abs_d) * SQ_W'(abs_d);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_sq_q <= '0;
      end else if (clear_stats) begin
         sum_sq_q <= '0;
      end else if (s2_vld_q) begin
         if (sum_sq_ext[SQS_W-1:ACC_W] != '0) begin
            sum_sq_q <= '1;
         end else begin
            sum_sq_q <= sum_sq_ext[ACC_W-1:0];
         end
      end
   end

   assign bus.sum_sq_err = sum_sq_q;
`else
   assign bus.sum_sq_err = '0;
`endif

   assign bus.in_ready    = (state_q == RUN);
   assign bus.busy        = (state_q == RUN) || (state_q == DRAIN);
   assign bus.done        = (state_q == DONE);
   assign bus.add_a       = add_a_q;
   assign bus.add_b       = add_b_q;
   assign bus.err_count   = err_cnt_q;
   assign bus.sum_abs_err = sum_abs_q;
   assign bus.max_abs_err = max_abs_q;
   assign state_o         = state_q;

endmodule
